// File: rtl/uart_pkg.sv
// Shared UART transmit constants and pacing-FSM state type.
// The values here must agree with every sender instance on the same line.
package uart_pkg;

    localparam int unsigned UART_COUNT_WIDTH = 32'd12;
    localparam logic [11:0] UART_COUNT_MAX   = 12'd2603;
    localparam int unsigned FRAME_BITS       = 32'd10;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } tx_state_e;

    // Cycles from a start pulse until sender is idle again: full frame plus its idle-sample cycle.
    function automatic int unsigned gap_cycles(input int unsigned count_max);
        return FRAME_BITS * (count_max + 32'd1) + 32'd1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO with power-of-two depth; head is readable combinationally.
// Pushes to a full FIFO and pops from an empty FIFO are ignored.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_LOG = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                push,
    input  logic [7:0]          push_data,
    input  logic                pop,
    output logic [7:0]          head,
    output logic                full,
    output logic                empty,
    output logic [FIFO_LOG:0]   count
);

    localparam int DEPTH = 1 << FIFO_LOG;
    localparam int CW    = FIFO_LOG + 1;

    logic [7:0]          r_mem [DEPTH];
    logic [FIFO_LOG-1:0] r_wr_ptr;
    logic [FIFO_LOG-1:0] r_rd_ptr;
    logic [FIFO_LOG:0]   r_count;
    logic                w_do_push;
    logic                w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == {CW{1'b0}});
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign head      = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= {FIFO_LOG{1'b0}};
            r_rd_ptr <= {FIFO_LOG{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_LOG'(1'b1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_LOG'(1'b1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1'b1);
                2'b01:   r_count <= r_count - CW'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; contents need no reset because occupancy gates every read.
    always_ff @(posedge CLK) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin front end for a single UART sender, with a shared FIFO
// and a pacing FSM that spaces start pulses so each lands after sender is idle.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned              COUNT_WIDTH = UART_COUNT_WIDTH,
    parameter logic [COUNT_WIDTH-1:0]   COUNT_MAX   = UART_COUNT_MAX,
    parameter int                       FIFO_LOG    = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [7:0]          in0_data,
    input  logic                in0_valid,
    output logic                in0_ready,
    input  logic [7:0]          in1_data,
    input  logic                in1_valid,
    output logic                in1_ready,
    output logic [7:0]          tx_data,
    output logic                tx_start,
    output logic                busy,
    output logic [FIFO_LOG:0]   fifo_count
);

    localparam int unsigned          GAP      = gap_cycles(32'(COUNT_MAX));
    localparam int                   GAP_W    = $clog2(GAP + 1);
    localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(GAP - 1);

    logic              w_full;
    logic              w_empty;
    logic [7:0]        w_head;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_push;
    logic [7:0]        w_push_data;
    logic              w_pop;
    logic              r_last;
    tx_state_e         r_state;
    tx_state_e         w_state_next;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [GAP_W-1:0]  w_gap_cnt_next;
    logic              r_tx_start;
    logic              w_tx_start_next;
    logic [7:0]        r_tx_data;
    logic [7:0]        w_tx_data_next;
    logic [FIFO_LOG:0] w_count;

    // Grant selection: a lone requester wins, a tie goes to whoever was not granted last.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!RST && !w_full) begin
            if (in0_valid && (!in1_valid || r_last)) begin
                w_grant0 = 1'b1;
            end else if (in1_valid) begin
                w_grant1 = 1'b1;
            end else begin
                w_grant0 = 1'b0;
            end
        end else begin
            w_grant1 = 1'b0;
        end
    end

    assign in0_ready   = w_grant0;
    assign in1_ready   = w_grant1;
    assign w_push      = w_grant0 || w_grant1;
    assign w_push_data = w_grant1 ? in1_data : in0_data;

    // Last-grant pointer moves only on an actual transfer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_last <= 1'b1;
        end else if (w_grant0) begin
            r_last <= 1'b0;
        end else if (w_grant1) begin
            r_last <= 1'b1;
        end else begin
            r_last <= r_last;
        end
    end

    uart_tx_fifo #(
        .FIFO_LOG (FIFO_LOG)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    // Pacing decisions: pop and launch from IDLE, then sit out GAP cycles in WAIT.
    always_comb begin
        w_state_next    = r_state;
        w_gap_cnt_next  = r_gap_cnt;
        w_tx_start_next = 1'b0;
        w_tx_data_next  = r_tx_data;
        w_pop           = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_tx_start_next = 1'b1;
                    w_tx_data_next  = w_head;
                    w_pop           = 1'b1;
                    w_gap_cnt_next  = {GAP_W{1'b0}};
                    w_state_next    = WAIT;
                end else begin
                    w_state_next = IDLE;
                end
            end
            WAIT: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_next = IDLE;
                end else begin
                    w_gap_cnt_next = r_gap_cnt + GAP_W'(1'b1);
                end
            end
            default: begin
                w_state_next   = WAIT;
                w_gap_cnt_next = {GAP_W{1'b0}};
            end
        endcase
    end

    // Reset lands in WAIT because sender may still be mid-frame when RST arrives.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= WAIT;
            r_gap_cnt  <= {GAP_W{1'b0}};
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_state    <= w_state_next;
            r_gap_cnt  <= w_gap_cnt_next;
            r_tx_start <= w_tx_start_next;
            r_tx_data  <= w_tx_data_next;
        end
    end

    assign tx_start   = r_tx_start;
    assign tx_data    = r_tx_data;
    assign busy       = !w_empty || (r_state != IDLE);
    assign fifo_count = w_count;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with COUNT_MAX=3 (GAP=41) and a 4-entry FIFO.
// A behavioural sender and queue-based scoreboard stand in for the real transmitter.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int GAP   = 41;
    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] in0_data = 8'h00;
    logic       in0_valid = 1'b0;
    logic       in0_ready;
    logic [7:0] in1_data = 8'h00;
    logic       in1_valid = 1'b0;
    logic       in1_ready;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic [2:0] fifo_count;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int         pulse_cyc[$];
    logic [7:0] pulse_data[$];

    uart_tx_arbiter #(
        .COUNT_WIDTH (12),
        .COUNT_MAX   (12'd3),
        .FIFO_LOG    (2)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in0_data   (in0_data),
        .in0_valid  (in0_valid),
        .in0_ready  (in0_ready),
        .in1_data   (in1_data),
        .in1_valid  (in1_valid),
        .in1_ready  (in1_ready),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 CLK = ~CLK;

    // Record every start pulse as seen by sender at the clock edge.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (tx_start === 1'b1) begin
            pulse_cyc.push_back(cyc);
            pulse_data.push_back(tx_data);
        end
    end

    // Behavioural sender: 10-bit frame, LSB first, 4 cycles per bit, no reset.
    logic [9:0] snd_shift = 10'h3ff;
    int         snd_bits  = 0;
    int         snd_baud  = 0;
    int         overlap   = 0;
    logic       snd_line;
    assign snd_line = (snd_bits != 0) ? snd_shift[0] : 1'b1;

    always @(posedge CLK) begin
        if (tx_start === 1'b1 && snd_bits != 0) overlap <= overlap + 1;
        if (snd_bits == 0) begin
            if (tx_start === 1'b1) begin
                snd_shift <= {1'b1, tx_data, 1'b0};
                snd_bits  <= 10;
                snd_baud  <= 0;
            end
        end else if (snd_baud == 3) begin
            snd_shift <= snd_shift >> 1;
            snd_bits  <= snd_bits - 1;
            snd_baud  <= 0;
        end else begin
            snd_baud <= snd_baud + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy !== 1'b0 && k < 2000) begin tick(); k++; end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL %s_idle_timeout: busy=%b expected 0", tag, busy); end
    endtask

    task automatic check_pulses(input string tag, input int base, input logic [7:0] exp_q[$]);
        tests++;
        if (pulse_data.size() - base != exp_q.size()) begin
            fails++;
            $display("FAIL %s_pulse_count: got %0d expected %0d", tag, pulse_data.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && base + i < pulse_data.size(); i++) begin
            tests++;
            if (pulse_data[base+i] !== exp_q[i]) begin
                fails++;
                $display("FAIL %s_data[%0d]: got %h expected %h", tag, i, pulse_data[base+i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        in0_valid = 1'b1; in0_data = 8'h11; in1_valid = 1'b1; in1_data = 8'h22;
        repeat (3) tick();
        #1;
        tests += 6;
        if (in0_ready !== 1'b0) begin fails++; $display("FAIL rst_in0_ready: got %b expected 0", in0_ready); end
        if (in1_ready !== 1'b0) begin fails++; $display("FAIL rst_in1_ready: got %b expected 0", in1_ready); end
        if (tx_start !== 1'b0) begin fails++; $display("FAIL rst_tx_start: got %b expected 0", tx_start); end
        if (tx_data !== 8'h00) begin fails++; $display("FAIL rst_tx_data: got %h expected 00", tx_data); end
        if (busy !== 1'b1) begin fails++; $display("FAIL rst_busy: got %b expected 1", busy); end
        if (fifo_count !== 3'd0) begin fails++; $display("FAIL rst_fifo_count: got %0d expected 0", fifo_count); end
        in0_valid = 1'b0; in1_valid = 1'b0; RST = 1'b0;
        repeat (GAP - 1) tick();
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL rst_busy_in_wait: got %b expected 1", busy); end
        tick();
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy_first_idle: got %b expected 0", busy); end
    endtask

    task automatic test_tie_break();
        logic [7:0] d0 = 8'h10;
        logic [7:0] d1 = 8'h20;
        logic [7:0] acc[$];
        logic [7:0] exp_q[$];
        int base;
        int both = 0;
        wait_idle("tie");
        base = pulse_data.size();
        in0_valid = 1'b1; in1_valid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            in0_data = d0; in1_data = d1;
            #1;
            if (in0_ready === 1'b1 && in1_ready === 1'b1) both++;
            if (in0_ready === 1'b1) begin acc.push_back(d0); d0++; end
            else if (in1_ready === 1'b1) begin acc.push_back(d1); d1++; end
            tick();
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        tests++;
        if (both != 0) begin fails++; $display("FAIL tie_double_grant: got %0d expected 0", both); end
        tests++;
        if (acc.size() < 4) begin fails++; $display("FAIL tie_accept_count: got %0d expected >=4", acc.size()); end
        // Both always valid from reset, so grants strictly alternate starting with requester 0.
        for (int i = 0; i < acc.size(); i++) begin
            logic [7:0] e;
            e = ((i % 2) == 0) ? 8'(8'h10 + i / 2) : 8'(8'h20 + i / 2);
            exp_q.push_back(e);
            tests++;
            if (acc[i] !== e) begin fails++; $display("FAIL tie_order[%0d]: got %h expected %h", i, acc[i], e); end
        end
        wait_idle("tie_drain");
        check_pulses("tie", base, exp_q);
        for (int i = base + 1; i < pulse_cyc.size(); i++) begin
            tests++;
            if (pulse_cyc[i] - pulse_cyc[i-1] != GAP + 1) begin
                fails++;
                $display("FAIL tie_spacing[%0d]: got %0d expected %0d", i - base, pulse_cyc[i] - pulse_cyc[i-1], GAP + 1);
            end
        end
    endtask

    task automatic test_single_byte();
        logic [9:0] frame = 10'b1101001010;
        wait_idle("single");
        in0_data = 8'hA5; in0_valid = 1'b1;
        #1;
        tests += 2;
        if (in0_ready !== 1'b1) begin fails++; $display("FAIL single_ready: got %b expected 1", in0_ready); end
        if (in1_ready !== 1'b0) begin fails++; $display("FAIL single_in1_ready: got %b expected 0", in1_ready); end
        tick();
        in0_valid = 1'b0;
        #1;
        tests += 2;
        if (fifo_count !== 3'd1) begin fails++; $display("FAIL single_count: got %0d expected 1", fifo_count); end
        if (tx_start !== 1'b0) begin fails++; $display("FAIL single_early_start: got %b expected 0", tx_start); end
        tick();
        tests += 3;
        if (tx_start !== 1'b1) begin fails++; $display("FAIL single_start: got %b expected 1", tx_start); end
        if (tx_data !== 8'hA5) begin fails++; $display("FAIL single_data: got %h expected a5", tx_data); end
        if (fifo_count !== 3'd0) begin fails++; $display("FAIL single_popped: got %0d expected 0", fifo_count); end
        for (int k = 0; k < 10; k++) begin
            repeat ((k == 0) ? 2 : 4) tick();
            if (k == 0) begin
                tests++;
                if (tx_start !== 1'b0) begin fails++; $display("FAIL single_pulse_width: got %b expected 0", tx_start); end
            end
            tests++;
            if (snd_line !== frame[k]) begin fails++; $display("FAIL single_line_bit[%0d]: got %b expected %b", k, snd_line, frame[k]); end
        end
    endtask

    task automatic lead_byte(input logic [7:0] b, output int c0);
        wait_idle("lead");
        in0_data = b; in0_valid = 1'b1;
        tick();
        in0_valid = 1'b0;
        tick();
        c0 = cyc;
        tests++;
        if (tx_start !== 1'b1) begin fails++; $display("FAIL lead_start: got %b expected 1", tx_start); end
    endtask

    task automatic test_full();
        int c0;
        int base;
        logic [7:0] exp_q[$];
        base = pulse_data.size();
        lead_byte(8'h30, c0);
        for (int i = 0; i < DEPTH; i++) begin
            in0_data = 8'(8'h31 + i); in0_valid = 1'b1;
            #1;
            tests++;
            if (in0_ready !== 1'b1) begin fails++; $display("FAIL full_fill_ready[%0d]: got %b expected 1", i, in0_ready); end
            tick();
        end
        in0_data = 8'h35; in1_data = 8'h40; in0_valid = 1'b1; in1_valid = 1'b1;
        #1;
        tests += 3;
        if (fifo_count !== 3'd4) begin fails++; $display("FAIL full_count: got %0d expected 4", fifo_count); end
        if (in0_ready !== 1'b0) begin fails++; $display("FAIL full_in0_ready: got %b expected 0", in0_ready); end
        if (in1_ready !== 1'b0) begin fails++; $display("FAIL full_in1_ready: got %b expected 0", in1_ready); end
        while (cyc < c0 + GAP) tick();
        #1;
        tests += 3;
        if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin fails++; $display("FAIL full_pop_cycle_ready: got %b%b expected 00", in0_ready, in1_ready); end
        if (tx_start !== 1'b0) begin fails++; $display("FAIL full_pop_cycle_start: got %b expected 0", tx_start); end
        if (fifo_count !== 3'd4) begin fails++; $display("FAIL full_pop_cycle_count: got %0d expected 4", fifo_count); end
        tick();
        #1;
        tests += 5;
        if (tx_start !== 1'b1) begin fails++; $display("FAIL full_second_start: got %b expected 1", tx_start); end
        if (tx_data !== 8'h31) begin fails++; $display("FAIL full_second_data: got %h expected 31", tx_data); end
        if (fifo_count !== 3'd3) begin fails++; $display("FAIL full_after_pop_count: got %0d expected 3", fifo_count); end
        if (in1_ready !== 1'b1) begin fails++; $display("FAIL full_reopen_in1: got %b expected 1", in1_ready); end
        if (in0_ready !== 1'b0) begin fails++; $display("FAIL full_reopen_in0: got %b expected 0", in0_ready); end
        tick();
        in0_valid = 1'b0; in1_valid = 1'b0;
        #1;
        tests++;
        if (fifo_count !== 3'd4) begin fails++; $display("FAIL full_refill_count: got %0d expected 4", fifo_count); end
        wait_idle("full");
        exp_q = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h40};
        check_pulses("full", base, exp_q);
    endtask

    task automatic test_simul_push_pop();
        int c0;
        int base;
        logic [7:0] exp_q[$];
        base = pulse_data.size();
        lead_byte(8'h50, c0);
        for (int i = 0; i < 2; i++) begin
            in0_data = 8'(8'h51 + i); in0_valid = 1'b1;
            tick();
        end
        in0_valid = 1'b0;
        while (cyc < c0 + GAP) tick();
        tests++;
        if (fifo_count !== 3'd2) begin fails++; $display("FAIL simul_pre_count: got %0d expected 2", fifo_count); end
        in0_data = 8'h53; in0_valid = 1'b1;
        #1;
        tests++;
        if (in0_ready !== 1'b1) begin fails++; $display("FAIL simul_ready: got %b expected 1", in0_ready); end
        tick();
        in0_valid = 1'b0;
        #1;
        tests += 3;
        if (fifo_count !== 3'd2) begin fails++; $display("FAIL simul_count: got %0d expected 2", fifo_count); end
        if (tx_start !== 1'b1) begin fails++; $display("FAIL simul_start: got %b expected 1", tx_start); end
        if (tx_data !== 8'h51) begin fails++; $display("FAIL simul_data: got %h expected 51", tx_data); end
        wait_idle("simul");
        exp_q = '{8'h50, 8'h51, 8'h52, 8'h53};
        check_pulses("simul", base, exp_q);
    endtask

    task automatic test_reset_midframe();
        int c0;
        int base;
        int early = 0;
        logic [7:0] exp_q[$];
        wait_idle("midrst");
        base = pulse_data.size();
        for (int i = 0; i < 3; i++) begin
            in1_data = 8'(8'h60 + i); in1_valid = 1'b1;
            tick();
        end
        in1_valid = 1'b0;
        tick();
        c0 = pulse_cyc[$];
        while (cyc < c0 + 10) tick();
        RST = 1'b1; in1_data = 8'h70; in1_valid = 1'b1;
        tick();
        #1;
        tests += 4;
        if (fifo_count !== 3'd0) begin fails++; $display("FAIL midrst_count: got %0d expected 0", fifo_count); end
        if (in1_ready !== 1'b0) begin fails++; $display("FAIL midrst_ready: got %b expected 0", in1_ready); end
        if (busy !== 1'b1) begin fails++; $display("FAIL midrst_busy: got %b expected 1", busy); end
        if (tx_start !== 1'b0) begin fails++; $display("FAIL midrst_start: got %b expected 0", tx_start); end
        RST = 1'b0;
        #1;
        tests++;
        if (in1_ready !== 1'b1) begin fails++; $display("FAIL midrst_post_ready: got %b expected 1", in1_ready); end
        tick();
        in1_valid = 1'b0;
        if (tx_start === 1'b1) early++;
        for (int k = 2; k <= GAP; k++) begin
            tick();
            if (tx_start === 1'b1) early++;
        end
        tests++;
        if (early != 0) begin fails++; $display("FAIL midrst_early_start: got %0d pulses expected 0", early); end
        tick();
        tests += 2;
        if (tx_start !== 1'b1) begin fails++; $display("FAIL midrst_first_start: got %b expected 1", tx_start); end
        if (tx_data !== 8'h70) begin fails++; $display("FAIL midrst_first_data: got %h expected 70", tx_data); end
        wait_idle("midrst");
        exp_q = '{8'h60, 8'h70};
        check_pulses("midrst", base, exp_q);
    endtask

    task automatic test_wraparound();
        logic [7:0] sent[$];
        logic [7:0] cur;
        int base;
        int over = 0;
        wait_idle("wrap");
        base = pulse_data.size();
        cur = 8'($urandom);
        for (int c = 0; c < 3000 && sent.size() < 20; c++) begin
            in1_valid = ($urandom_range(0, 3) != 0);
            in1_data = cur;
            #1;
            if (fifo_count > 3'd4) over++;
            if (in1_valid && in1_ready === 1'b1) begin sent.push_back(cur); cur = 8'($urandom); end
            tick();
        end
        in1_valid = 1'b0;
        tests += 2;
        if (sent.size() != 20) begin fails++; $display("FAIL wrap_accepted: got %0d expected 20", sent.size()); end
        if (over != 0) begin fails++; $display("FAIL wrap_overfill: got %0d expected 0", over); end
        wait_idle("wrap");
        check_pulses("wrap", base, sent);
    endtask

    task automatic test_pacing_global();
        int min_gap = 1000000;
        for (int i = 1; i < pulse_cyc.size(); i++)
            if (pulse_cyc[i] - pulse_cyc[i-1] < min_gap) min_gap = pulse_cyc[i] - pulse_cyc[i-1];
        tests += 2;
        if (overlap != 0) begin fails++; $display("FAIL sender_overlap: got %0d expected 0", overlap); end
        if (min_gap < GAP + 1) begin fails++; $display("FAIL min_spacing: got %0d expected >=%0d", min_gap, GAP + 1); end
    endtask

    initial begin
        test_reset();
        test_tie_break();
        test_single_byte();
        test_full();
        test_simul_push_pop();
        test_reset_midframe();
        test_wraparound();
        test_pacing_global();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
